vdiv_sqrt_unit: RTL and testbench
=================================

Name: vdiv_sqrt_unit

Overview:
- Multi-cycle, parametrised unsigned vector divide / modulo / square-root unit for the R-type vector datapath.
- Offloads VDIV, VMOD and VSQRT from the combinational ALU and completes them iteratively over all lanes in parallel.
- Valid/ready handshake on both sides; result is held until it is accepted.
- Lane width is selected by the WW field, as in the rest of the vector datapath.

Parameters:
- DATA_W, 64, vector width; must be a multiple of 64. Each 64-bit slice is segmented independently.
- BITS_PER_CYC, 1, quotient or root bits produced per iteration cycle; legal values 1 and 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands and op are valid
- in_ready  out  1  unit can accept; high only in IDLE
- rA_val  in  [0:DATA_W-1]  dividend or radicand; bit 0 is the MSB
- rB_val  in  [0:DATA_W-1]  divisor; ignored for VSQRT
- R_ins  in  [0:5]  function: 001110 VDIV, 001111 VMOD, 010010 VSQRT
- WW  in  [0:1]  lane width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  [0:DATA_W-1]  result; lane k occupies bits [k*LW : k*LW+LW-1]
- out_err  out  1  unsupported R_ins

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-low: state is sampled on the rising clk edge while rst_n = 0.
  - Reset values: state IDLE, out_valid 0, out_data 0, out_err 0, iteration counter 0. in_ready is 1 (it is decoded from state == IDLE).
- States:
  - IDLE: in_ready = 1. When in_valid is high at an edge, capture rA_val, rB_val, R_ins and WW, load the counter with N, and go to RUN.
  - N = LW / BITS_PER_CYC for VDIV and VMOD, and (LW/2) / BITS_PER_CYC for VSQRT, where LW is the lane width.
  - RUN: perform one iteration per edge and decrement the counter. The edge on which the counter reaches 0 writes out_data and enters DONE.
  - DONE: out_valid = 1 and out_data/out_err are held stable. Exit to IDLE on the edge where out_ready = 1. in_ready stays 0 in DONE, so there is no same-cycle reissue.
- Latency:
  - out_valid rises exactly N+1 edges after the accepting edge.
  - Example: 64-bit VDIV with BITS_PER_CYC = 1 takes 65 edges.
- Illegal R_ins:
  - Goes from IDLE straight to DONE on the accepting edge (latency 1).
  - out_data = 0 and out_err = 1.
  - out_err is 0 for every legal op.
- Arithmetic (unsigned, per lane, restoring):
  - VDIV: out = floor(A/B).
  - VMOD: out = A mod B.
  - VSQRT: out = floor(sqrt(A)), zero-extended within the lane.
- Divide by zero, per lane:
  - VDIV returns all ones for that lane.
  - VMOD returns A for that lane.
  - Other lanes are unaffected.
- Lane isolation: no carry or borrow crosses a lane boundary. WW is latched at acceptance; changes to WW mid-operation are ignored.
- Reset mid-operation (rst_n low during RUN or DONE): abort and return to the reset values on that edge. No result is produced.
- Inputs other than in_valid are don't-care outside IDLE.

Optional Feature:
- VDSU_DBZ_FLAG_EN defined:
  - Adds output port dbz_mask [0:DATA_W/8-1].
  - Bit j is set in DONE when byte position j lies in a lane whose divisor is zero, for VDIV or VMOD.
  - The mask is 0 for VSQRT and illegal ops, and resets to 0.
- Undefined: the port is absent. Divide-by-zero results are still produced as specified above.

Decomposition:
- Package vdsu_pkg:
  - R_ins function constants for VDIV, VMOD and VSQRT.
  - WW encodings and a lane-width lookup function.
  - State enum {IDLE, RUN, DONE}.
  - Iteration-count function of (op, WW, BITS_PER_CYC).
- Sub-module vdsu_slice64:
  - One 64-bit segmented iteration step (div or sqrt) with partial-remainder/quotient registers, handling 8/16/32/64-bit segmentation.
  - Instantiated DATA_W/64 times.
  - The top level holds the FSM, counter and handshake.

Test Plan:
- VDIV WW=00, rA = FF00FF00_FF00FF00, rB = 11221122_44444444 -> out_data 0F000F00_03000300; out_valid rises exactly 9 edges after acceptance.
- VMOD WW=11, rA = 102, rB = 10 -> out_data 2; latency 65 edges; in_ready low for the whole operation.
- VSQRT WW=00, rA = FF01FFFF_10040001 -> out_data 0F010F0F_04020001; latency 5 edges.
- Divide by zero, WW=10, rA = 00000064_00000007, rB = 00000000_00000002:
  - VDIV -> FFFFFFFF_00000003.
  - VMOD -> 00000064_00000001.
  - With the macro defined: dbz_mask = F0.
- Backpressure and reset:
  - Hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_data stay stable.
  - The unit returns to IDLE one edge after out_ready = 1.
  - rst_n = 0 during RUN -> out_valid 0 and in_ready 1 on the following cycle.
- Illegal R_ins = 000110 -> out_valid 1 edge after acceptance, out_err = 1, out_data = 0.

Source files
------------

// File: rtl/vdsu_pkg.sv
// vdsu_pkg: op codes, lane-width encodings, FSM state type and the
// iteration-count helper shared by the vdiv_sqrt_unit files.
package vdsu_pkg;

  localparam logic [5:0] OP_VDIV  = 6'b001110;
  localparam logic [5:0] OP_VMOD  = 6'b001111;
  localparam logic [5:0] OP_VSQRT = 6'b010010;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  // Wide enough to hold the largest iteration count (64).
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Lane width in bits for a WW encoding.
  function automatic logic [CNT_W-1:0] lane_width(input logic [1:0] ww);
    logic [CNT_W-1:0] lw;
    case (ww)
      WW_8:    lw = 7'd8;
      WW_16:   lw = 7'd16;
      WW_32:   lw = 7'd32;
      WW_64:   lw = 7'd64;
      default: lw = 7'd64;
    endcase
    return lw;
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_VDIV) || (op == OP_VMOD) || (op == OP_VSQRT);
  endfunction

  // Number of RUN iterations: one result bit per lane bit for divide,
  // one root bit per radicand bit pair for square root.
  function automatic logic [CNT_W-1:0] iter_count(input logic [5:0] op,
                                                  input logic [1:0] ww,
                                                  input int bits_per_cyc);
    logic [CNT_W-1:0] bits;
    bits = lane_width(ww);
    if (op == OP_VSQRT) begin
      bits = bits >> 1;
    end else begin
      bits = bits;
    end
    if (bits_per_cyc == 32'sd2) begin
      bits = bits >> 1;
    end else begin
      bits = bits;
    end
    return bits;
  endfunction

endpackage

// File: rtl/vdsu_slice64.sv
// vdsu_slice64: one 64-bit slice of the divide/sqrt datapath. Holds the
// shifting operand, divisor, partial remainder and partial quotient/root,
// and advances BITS_PER_CYC restoring iterations per step pulse for every
// lane of the latched width (8/16/32/64). Lanes never interact.
module vdsu_slice64
  import vdsu_pkg::*;
#(
  parameter int BITS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_sqrt,
  input  logic [1:0]  ww,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  output logic [63:0] q_nxt,
  output logic [63:0] rem_nxt
);

  logic [63:0] a_r;
  logic [63:0] b_r;
  logic [63:0] rem_r;
  logic [63:0] q_r;

  // Next-state candidates for each of the four lane widths.
  logic [3:0][63:0] a_w_s;
  logic [3:0][63:0] rem_w_s;
  logic [3:0][63:0] q_w_s;
  logic [63:0]      a_nxt_s;

  for (genvar w = 0; w < 4; w++) begin : g_width
    localparam int LW = 8 << w;
    for (genvar l = 0; l < 64 / LW; l++) begin : g_lane
      localparam int LO = l * LW;
      logic [LW-1:0] a_v;
      logic [LW-1:0] b_v;
      logic [LW-1:0] rem_v;
      logic [LW-1:0] q_v;
      logic [LW+1:0] trem_v;
      logic [LW+1:0] trial_v;
      logic [LW:0]   tdiv_v;

      // Restoring iterations for this lane: divide brings in one dividend
      // bit, square root brings in two radicand bits per iteration.
      always_comb begin
        a_v     = a_r[LO +: LW];
        b_v     = b_r[LO +: LW];
        rem_v   = rem_r[LO +: LW];
        q_v     = q_r[LO +: LW];
        trem_v  = {(LW+2){1'b0}};
        trial_v = {(LW+2){1'b0}};
        tdiv_v  = {(LW+1){1'b0}};
        for (int i = 0; i < BITS_PER_CYC; i++) begin
          if (is_sqrt) begin
            trem_v  = {rem_v, a_v[LW-1 -: 2]};
            trial_v = {q_v, 2'b01};
            if (trem_v >= trial_v) begin
              trem_v = trem_v - trial_v;
              q_v    = {q_v[LW-2:0], 1'b1};
            end else begin
              q_v    = {q_v[LW-2:0], 1'b0};
            end
            rem_v = trem_v[LW-1:0];
            a_v   = {a_v[LW-3:0], 2'b00};
          end else begin
            // A zero divisor always "fits": quotient goes all ones and
            // the remainder ends up equal to the dividend.
            tdiv_v = {rem_v, a_v[LW-1]};
            if (tdiv_v >= {1'b0, b_v}) begin
              tdiv_v = tdiv_v - {1'b0, b_v};
              q_v    = {q_v[LW-2:0], 1'b1};
            end else begin
              q_v    = {q_v[LW-2:0], 1'b0};
            end
            rem_v = tdiv_v[LW-1:0];
            a_v   = {a_v[LW-2:0], 1'b0};
          end
        end
      end

      assign a_w_s[w][LO +: LW]   = a_v;
      assign rem_w_s[w][LO +: LW] = rem_v;
      assign q_w_s[w][LO +: LW]   = q_v;
    end
  end

  assign a_nxt_s = a_w_s[ww];
  assign rem_nxt = rem_w_s[ww];
  assign q_nxt   = q_w_s[ww];

  // Capture operands on load, advance one iteration step per step pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= 64'd0;
      b_r   <= 64'd0;
      rem_r <= 64'd0;
      q_r   <= 64'd0;
    end else if (load) begin
      a_r   <= a_in;
      b_r   <= b_in;
      rem_r <= 64'd0;
      q_r   <= 64'd0;
    end else if (step) begin
      a_r   <= a_nxt_s;
      rem_r <= rem_nxt;
      q_r   <= q_nxt;
    end
  end

endmodule

// File: rtl/vdiv_sqrt_unit.sv
// vdiv_sqrt_unit: iterative unsigned VDIV / VMOD / VSQRT over all lanes of
// a DATA_W-bit vector, with valid/ready on both sides. Bit 0 of every
// vector port is the MSB. Optional feature macro: VDSU_DBZ_FLAG_EN adds
// the dbz_mask output (bytes lying in a lane with a zero divisor).
module vdiv_sqrt_unit
  import vdsu_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int BITS_PER_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] rA_val,
  input  logic [0:DATA_W-1] rB_val,
  input  logic [0:5]        R_ins,
  input  logic [0:1]        WW,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_data,
  output logic              out_err
`ifdef VDSU_DBZ_FLAG_EN
  ,
  output logic [0:DATA_W/8-1] dbz_mask
`endif
);

  localparam int NSLICE = DATA_W / 64;
  localparam int NBYTE  = DATA_W / 8;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [5:0]       op_r;
  logic [1:0]       ww_r;

  // Numeric (LSB at index 0) views of the MSB-first vector ports.
  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W-1:0] q_nxt_s;
  logic [DATA_W-1:0] rem_nxt_s;
  logic [DATA_W-1:0] res_s;
  logic              legal_s;
  logic              load_s;
  logic              step_s;
  logic              is_sqrt_s;

  assign a_s       = rA_val;
  assign b_s       = rB_val;
  assign legal_s   = is_legal_op(R_ins);
  assign load_s    = (state_r == IDLE) && in_valid && legal_s;
  assign step_s    = (state_r == RUN);
  assign is_sqrt_s = (op_r == OP_VSQRT);
  assign in_ready  = (state_r == IDLE);

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    vdsu_slice64 #(
      .BITS_PER_CYC(BITS_PER_CYC)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_s),
      .step    (step_s),
      .is_sqrt (is_sqrt_s),
      .ww      (ww_r),
      .a_in    (a_s[s*64 +: 64]),
      .b_in    (b_s[s*64 +: 64]),
      .q_nxt   (q_nxt_s[s*64 +: 64]),
      .rem_nxt (rem_nxt_s[s*64 +: 64])
    );
  end

  // VMOD delivers the remainder; VDIV and VSQRT deliver quotient / root.
  assign res_s = (op_r == OP_VMOD) ? rem_nxt_s : q_nxt_s;

  // Handshake FSM, iteration counter and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 6'd0;
      ww_r      <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
      out_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r <= R_ins;
            ww_r <= WW;
            if (legal_s) begin
              cnt_r   <= iter_count(R_ins, WW, BITS_PER_CYC);
              out_err <= 1'b0;
              state_r <= RUN;
            end else begin
              out_data  <= {DATA_W{1'b0}};
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end
          end
        end
        RUN: begin
          cnt_r <= cnt_r - 7'd1;
          // Last iteration: its result goes straight into out_data.
          if (cnt_r == 7'd1) begin
            out_data  <= res_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef VDSU_DBZ_FLAG_EN
  logic [NBYTE-1:0] zero_lane_s;
  logic [NBYTE-1:0] dbz_pend_r;

  // Flag every byte that sits in a lane whose whole divisor is zero.
  always_comb begin
    int   lane_bytes;
    int   first;
    logic z;
    zero_lane_s = {NBYTE{1'b0}};
    lane_bytes  = 32'd1 << WW;
    first       = 0;
    z           = 1'b0;
    for (int p = 0; p < NBYTE; p++) begin
      first = p - (p % lane_bytes);
      z     = 1'b1;
      for (int q = 0; q < 8; q++) begin
        if (q < lane_bytes) begin
          z = z & (b_s[8*(first+q) +: 8] == 8'h00);
        end else begin
          z = z;
        end
      end
      zero_lane_s[p] = z;
    end
  end

  // Capture the zero-divisor byte mask at acceptance and present it in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dbz_pend_r <= {NBYTE{1'b0}};
      dbz_mask   <= {NBYTE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && legal_s && (R_ins != OP_VSQRT)) begin
            dbz_pend_r <= zero_lane_s;
          end else if (in_valid) begin
            dbz_pend_r <= {NBYTE{1'b0}};
          end
        end
        RUN: begin
          if (cnt_r == 7'd1) begin
            dbz_mask <= dbz_pend_r;
          end
        end
        DONE: begin
          if (out_ready) begin
            dbz_mask <= {NBYTE{1'b0}};
          end
        end
        default: begin
          dbz_mask <= {NBYTE{1'b0}};
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_vdiv_sqrt_unit.sv
// tb_vdiv_sqrt_unit: directed vectors for vdiv_sqrt_unit, checked against a
// lane-by-lane arithmetic model (plain / , % and integer sqrt).
module tb_vdiv_sqrt_unit;

  localparam int DATA_W = 64;
  localparam int BPC    = 1;

  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;
  localparam logic [5:0] VSQRT = 6'b010010;
  localparam logic [5:0] ILL   = 6'b000110;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [0:DATA_W-1] rA_val    = '0;
  logic [0:DATA_W-1] rB_val    = '0;
  logic [0:5]        R_ins     = '0;
  logic [0:1]        WW        = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [0:DATA_W-1] out_data;
  logic              out_err;
`ifdef VDSU_DBZ_FLAG_EN
  logic [0:DATA_W/8-1] dbz_mask;
  logic [7:0]          exp_dbz = 8'h00;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [63:0] exp_data = 64'd0;
  logic        exp_err  = 1'b0;
  bit          exp_armed = 1'b0;
  bit          busy      = 1'b0;

  vdiv_sqrt_unit #(
    .DATA_W      (DATA_W),
    .BITS_PER_CYC(BPC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rA_val   (rA_val),
    .rB_val   (rB_val),
    .R_ins    (R_ins),
    .WW       (WW),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
`ifdef VDSU_DBZ_FLAG_EN
    ,
    .dbz_mask (dbz_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    longint unsigned c;
    r = 0;
    for (int bi = 31; bi >= 0; bi--) begin
      c = r | (64'd1 << bi);
      if (c * c <= x) r = c;
    end
    return r;
  endfunction

  function automatic logic [63:0] model_res(input logic [5:0] op, input logic [1:0] ww,
                                            input logic [63:0] a, input logic [63:0] b);
    int lw;
    longint unsigned msk, la, lb, r;
    logic [63:0] res;
    lw  = 8 << ww;
    msk = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    res = 64'd0;
    for (int k = 0; k < 64 / lw; k++) begin
      la = (a >> (k * lw)) & msk;
      lb = (b >> (k * lw)) & msk;
      if (op == VDIV)       r = (lb == 0) ? msk : la / lb;
      else if (op == VMOD)  r = (lb == 0) ? la : la % lb;
      else if (op == VSQRT) r = isqrt(la);
      else                  r = 0;
      res = res | ((r & msk) << (k * lw));
    end
    return res;
  endfunction

  // Edges from acceptance (acceptance edge counted as 1) until out_valid.
  function automatic int model_lat(input logic [5:0] op, input logic [1:0] ww);
    int lw;
    lw = 8 << ww;
    if (op == VDIV || op == VMOD) return lw / BPC + 1;
    if (op == VSQRT) return (lw / 2) / BPC + 1;
    return 1;
  endfunction

`ifdef VDSU_DBZ_FLAG_EN
  function automatic logic [7:0] model_dbz(input logic [5:0] op, input logic [1:0] ww,
                                           input logic [63:0] b);
    int lw;
    logic [7:0] m;
    longint unsigned msk, lb;
    m = 8'h00;
    if (op != VDIV && op != VMOD) return m;
    lw  = 8 << ww;
    msk = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    for (int k = 0; k < 64 / lw; k++) begin
      lb = (b >> (k * lw)) & msk;
      if (lb == 0) begin
        for (int p = k * lw / 8; p < (k + 1) * lw / 8; p++) m[p] = 1'b1;
      end
    end
    return m;
  endfunction
`endif

  // Single compare process: result fields against the model whenever a
  // result is presented, and in_ready against the bench's busy tracking.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_busy", in_ready, !busy);
      if (out_valid && exp_armed) begin
        check("out_data", out_data, exp_data);
        check("out_err", out_err, exp_err);
`ifdef VDSU_DBZ_FLAG_EN
        check("dbz_mask", dbz_mask, exp_dbz);
`endif
      end
    end
  end

  task automatic run_op(input logic [5:0] op, input logic [1:0] ww,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
    int guard;
    int lat;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_wait", in_ready, 1'b1);
    R_ins     = op;
    WW        = ww;
    rA_val    = a;
    rB_val    = b;
    in_valid  = 1'b1;
    exp_data  = model_res(op, ww, a, b);
    exp_err   = !(op == VDIV || op == VMOD || op == VSQRT);
`ifdef VDSU_DBZ_FLAG_EN
    exp_dbz   = model_dbz(op, ww, b);
`endif
    exp_armed = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    // Scramble the don't-care inputs while the unit is busy.
    rA_val = ~a;
    rB_val = 64'd0;
    WW     = ~ww;
    R_ins  = VSQRT;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(model_lat(op, ww)));
    repeat (hold) @(posedge clk);
    #1;
    check("valid_held", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    busy      = 1'b0;
    exp_armed = 1'b0;
    check("back_to_idle", in_ready, 1'b1);
    check("valid_dropped", out_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
`ifdef VDSU_DBZ_FLAG_EN
    check("rst_dbz_mask", dbz_mask, 8'h00);
    check("pin_dbz", model_dbz(VDIV, 2'b10, 64'h00000000_00000002), 8'hF0);
`endif
    rst_n = 1'b1;

    // Hand-computed values pinning the model.
    check("pin_vdiv8", model_res(VDIV, 2'b00, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444),
          64'h0F000F00_03000300);
    check("pin_vmod64", model_res(VMOD, 2'b11, 64'd102, 64'd10), 64'd2);
    check("pin_vsqrt8", model_res(VSQRT, 2'b00, 64'hFF01FFFF_10040001, 64'd0),
          64'h0F010F0F_04020001);
    check("pin_dbz_div", model_res(VDIV, 2'b10, 64'h00000064_00000007, 64'h00000000_00000002),
          64'hFFFFFFFF_00000003);
    check("pin_dbz_mod", model_res(VMOD, 2'b10, 64'h00000064_00000007, 64'h00000000_00000002),
          64'h00000064_00000001);
    check("pin_vsqrt64", model_res(VSQRT, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'd0), 64'h00000000_FFFFFFFF);
    check("pin_illegal", model_res(ILL, 2'b01, 64'h1234, 64'h5), 64'd0);

    run_op(VDIV,  2'b00, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, 0);
    run_op(VMOD,  2'b11, 64'd102, 64'd10, 0);
    run_op(VSQRT, 2'b00, 64'hFF01FFFF_10040001, 64'd0, 0);
    run_op(VDIV,  2'b10, 64'h00000064_00000007, 64'h00000000_00000002, 0);
    run_op(VMOD,  2'b10, 64'h00000064_00000007, 64'h00000000_00000002, 10);
    run_op(ILL,   2'b01, 64'h12345678_9ABCDEF0, 64'h11111111_11111111, 2);
    run_op(VDIV,  2'b01, 64'hFFFF1234_010000FF, 64'h00030010_00000010, 0);
    run_op(VSQRT, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 0);
    run_op(VSQRT, 2'b10, 64'h00000010_FFFFFFFF, 64'd0, 0);
    run_op(VMOD,  2'b00, 64'hFF7F0AC8_64FE0309, 64'h10000703_0A000205, 1);
    run_op(VDIV,  2'b11, 64'hFEDCBA98_76543210, 64'h00000000_00012345, 0);
    run_op(VSQRT, 2'b01, 64'hFFFF0090_40000002, 64'd0, 0);

    // Reset in the middle of a RUN aborts without a result.
    @(negedge clk);
    R_ins = VDIV; WW = 2'b11; rA_val = 64'd1000; rB_val = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    busy     = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    busy = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("midrst_no_result", out_valid, 1'b0);

    run_op(VDIV, 2'b11, 64'd1000, 64'd7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
